// File: rtl/mem_access_unit.sv
// Load/store unit between a core and a single-port, word-wide data memory.
// Sub-word stores take an extra MERGE cycle to read-modify-write the target word.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_lane;
    logic [1:0]            r_size;
    logic [31:0]           r_data;

    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [31:0]           r_resp_rdata;

    logic                  w_resp_valid_d;
    logic                  w_resp_err_d;
    logic [31:0]           w_resp_rdata_d;
    logic                  w_latch;
    logic                  w_accept;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic                  w_unused;

    // Upper address bits are deliberately dropped so accesses wrap around the memory.
    assign w_word_idx = req_addr[ADDR_WIDTH+1:2];
    assign w_unused   = &{1'b0, req_addr[31:ADDR_WIDTH+2]};

    assign w_err = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    assign w_accept = req_valid && req_ready;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size);
        logic [31:0] res;
        res = old;
        if (size == 2'b00) begin
            res[{lane, 3'b000} +: 8] = data[7:0];
        end else begin
            res[{lane[1], 4'b0000} +: 16] = data[15:0];
        end
        return res;
    endfunction

    always_comb begin
        w_next_state   = r_state;
        w_resp_valid_d = 1'b0;
        w_resp_err_d   = 1'b0;
        w_resp_rdata_d = 32'h0;
        w_latch        = 1'b0;
        req_ready      = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = w_word_idx;
        mem_wdata      = req_wdata;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    if (w_err) begin
                        w_resp_valid_d = 1'b1;
                        w_resp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        w_resp_valid_d = 1'b1;
                        w_resp_rdata_d = load_extract(mem_rdata, req_addr[1:0],
                                                      req_size, req_unsigned);
                    end else if (req_size == 2'b10) begin
                        mem_we         = rst;
                        w_resp_valid_d = 1'b1;
                    end else begin
                        w_latch      = 1'b1;
                        w_next_state = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_addr       = r_addr;
                mem_wdata      = merge_lane(mem_rdata, r_data, r_lane, r_size);
                mem_we         = rst;
                w_resp_valid_d = 1'b1;
                w_next_state   = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_addr       <= '0;
            r_lane       <= 2'b00;
            r_size       <= 2'b00;
            r_data       <= 32'h0;
        end else begin
            r_state      <= w_next_state;
            r_resp_valid <= w_resp_valid_d;
            r_resp_err   <= w_resp_err_d;
            r_resp_rdata <= w_resp_rdata_d;
            if (w_latch) begin
                r_addr <= w_word_idx;
                r_lane <= req_addr[1:0];
                r_size <= req_size;
                r_data <= req_wdata;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, corner-case sequences and
// random requests scored against a byte-level reference memory.
module tb_mem_access_unit;

    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    logic [31:0] mem     [1<<AW];
    logic [31:0] ref_mem [1<<AW];
    int          wr_cnt;
    int          checks;
    int          errors;

    mem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: pure byte-lane arithmetic on a word array.
    function automatic void ref_access(input logic we, input logic [1:0] size, input logic uns,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err,
                                       output int lat, output int wr);
        int          idx;
        int          sh;
        logic [31:0] w;
        logic [31:0] mask;
        idx   = int'(addr[AW+1:2]);
        err   = (size == 3) || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 0);
        rdata = 0;
        lat   = 1;
        wr    = 0;
        if (err) return;
        sh = (size == 1) ? 16 * int'(addr[1]) : 8 * int'(addr[1:0]);
        if (size == 2) sh = 0;
        mask = (size == 0) ? (32'hFF << sh) : (size == 1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
        w = ref_mem[idx];
        if (we) begin
            ref_mem[idx] = (w & ~mask) | ((wdata << sh) & mask);
            wr  = 1;
            lat = (size == 2) ? 1 : 2;
        end else begin
            rdata = (w & mask) >> sh;
            if (!uns && size == 0 && rdata >= 128)   rdata = rdata - 256;
            if (!uns && size == 1 && rdata >= 32768) rdata = rdata - 65536;
        end
    endfunction

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int busy, output int wr);
        int w0;
        @(negedge clk);
        chk("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        w0           = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!resp_valid && lat < 6) begin
            if (!req_ready) busy++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) lat = 99;
        rdata = resp_rdata;
        err   = resp_err;
        wr    = wr_cnt - w0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, busy, wr, elat, ewr;
        logic        rwe, runs;
        logic [1:0]  rsize;
        logic [31:0] raddr, rwdata;
        int          w0;

        checks = 0;
        errors = 0;
        wr_cnt = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h8,  32'hDEADBEEF, 32'h0,        1'b0, 1};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h8,  32'h0,        32'hDEADBEEF, 1'b0, 1};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h9,  32'h00000055, 32'h0,        1'b0, 2};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h8,  32'h0,        32'hDEAD55EF, 1'b0, 1};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'hB,  32'h0,        32'hFFFFFFDE, 1'b0, 1};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'hB,  32'h0,        32'h000000DE, 1'b0, 1};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h8,  32'h0,        32'h000055EF, 1'b0, 1};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h3,  32'h0,        32'h0,        1'b1, 1};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h6,  32'h0,        32'h0,        1'b1, 1};
        vecs[9]  = '{1'b1, 2'b11, 1'b0, 32'h8,  32'h12345678, 32'h0,        1'b1, 1};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h5,  32'h00001111, 32'h0,        1'b1, 1};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'hA,  32'hFFFF1234, 32'h0,        1'b0, 2};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h8,  32'h0,        32'h123455EF, 1'b0, 1};
        vecs[13] = '{1'b1, 2'b00, 1'b0, 32'hB,  32'hFFFFFF80, 32'h0,        1'b0, 2};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 32'hB,  32'h0,        32'hFFFFFF80, 1'b0, 1};
        vecs[15] = '{1'b0, 2'b01, 1'b1, 32'hA,  32'h0,        32'h00008034, 1'b0, 1};

        // Reset: outputs quiet and no write even with a word store presented.
        rst          = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h8;
        req_wdata    = 32'hFFFFFFFF;
        #1;
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        chk("rst_no_write", wr_cnt, 0);

        // Directed vectors.
        for (int i = 0; i < 16; i++) begin
            ref_access(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                       erd, eer, elat, ewr);
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   rd, er, lat, busy, wr);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_lat - 1);
            chk($sformatf("vec%0d_writes", i), wr, (vecs[i].we && !vecs[i].exp_err) ? 1 : 0);
        end

        // Address wrap: 0x1008 lands on word 2.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h1008;
        req_wdata = 32'hCAFEF00D;
        #1;
        chk("wrap_mem_addr", {22'h0, mem_addr}, 32'h2);
        chk("wrap_mem_we", {31'h0, mem_we}, 32'h1);
        ref_access(1'b1, 2'b10, 1'b0, 32'h1008, 32'hCAFEF00D, erd, eer, elat, ewr);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("wrap_resp_valid", {31'h0, resp_valid}, 32'h1);
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, er, lat, busy, wr);
        chk("wrap_readback", rd, 32'hCAFEF00D);

        // Idle with no request: address follows req_addr, no write.
        @(negedge clk);
        req_addr = 32'h3FC;
        #1;
        chk("idle_mem_addr", {22'h0, mem_addr}, 32'hFF);
        chk("idle_mem_we", {31'h0, mem_we}, 32'h0);

        // Back-to-back store then load of the same word.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h10;
        req_wdata = 32'h0BADCAFE;
        ref_access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0BADCAFE, erd, eer, elat, ewr);
        @(posedge clk);
        #1;
        chk("b2b_store_valid", {31'h0, resp_valid}, 32'h1);
        chk("b2b_store_rdata", resp_rdata, 32'h0);
        chk("b2b_ready", {31'h0, req_ready}, 32'h1);
        req_we = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_load_valid", {31'h0, resp_valid}, 32'h1);
        chk("b2b_load_rdata", resp_rdata, 32'h0BADCAFE);

        // Reset in the middle of MERGE aborts the byte store.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h8;
        req_wdata = 32'h77;
        w0        = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_in_merge", {31'h0, req_ready}, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_mem_we", {31'h0, mem_we}, 32'h0);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_no_resp", {31'h0, resp_valid}, 32'h0);
        chk("abort_no_write", wr_cnt - w0, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, er, lat, busy, wr);
        chk("abort_word_kept", rd, ref_mem[2]);

        // Random traffic over a few words, with high address bits scrambled.
        for (int n = 0; n < 300; n++) begin
            rwe    = 1'($urandom_range(0, 1));
            rsize  = 2'($urandom_range(0, 3));
            runs   = 1'($urandom_range(0, 1));
            raddr  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            rwdata = $urandom;
            ref_access(rwe, rsize, runs, raddr, rwdata, erd, eer, elat, ewr);
            do_req(rwe, rsize, runs, raddr, rwdata, rd, er, lat, busy, wr);
            chk($sformatf("rnd%0d_rdata a=%h sz=%0d we=%0d", n, raddr, rsize, rwe), rd, erd);
            chk($sformatf("rnd%0d_err", n), {31'h0, er}, {31'h0, eer});
            chk($sformatf("rnd%0d_lat", n), lat, elat);
            chk($sformatf("rnd%0d_writes", n), wr, ewr);
        end

        // Final sweep of the touched region against the reference.
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
